// File: rtl/mult_pkg.sv
// Shared widths and the radix-4 Booth digit encoding for the signed multiplier.
// The digit encoder lives here so every Booth row decodes its bits the same way.
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int PW    = 2 * WIDTH;
    localparam int NPP   = WIDTH / 2;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}; both all-zero and all-one encode digit 0.
    function automatic booth_digit_t boothEncode(input logic [2:0] triplet);
        booth_digit_t digit;
        digit = '0;
        case (triplet)
            3'b001, 3'b010: digit = '{neg: 1'b0, one: 1'b1, two: 1'b0};
            3'b011:         digit = '{neg: 1'b0, one: 1'b0, two: 1'b1};
            3'b100:         digit = '{neg: 1'b1, one: 1'b0, two: 1'b1};
            3'b101, 3'b110: digit = '{neg: 1'b1, one: 1'b1, two: 1'b0};
            default:        digit = '0;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bit-parallel 3:2 carry-save adder; the carry vector is pre-shifted into its weight
// and the bit pushed past the top is dropped because all arithmetic is modulo 2^N.
module csa_3to2 #(
    parameter int N = 64
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    logic [N-1:0] majority;

    assign sum      = x ^ y ^ z;
    assign majority = (x & y) | (x & z) | (y & z);
    assign carry    = {majority[N-2:0], 1'b0};

endmodule

// File: rtl/multiplier.sv
// Signed WIDTH x WIDTH multiplier: radix-4 Booth rows, a carry-save array reduction,
// one carry-propagate adder and a single output register (one-cycle latency).
module multiplier
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [PW-1:0]    result
);

    localparam int NVEC = NPP + 1;
    localparam int NCSA = NVEC - 2;

    logic [WIDTH:0]  bExt;
    logic [PW-1:0]   aExt;
    logic [PW-1:0]   ppRow    [NVEC];
    logic [PW-1:0]   csaSum   [NCSA];
    logic [PW-1:0]   csaCarry [NCSA];
    logic [PW-1:0]   result_d;
    logic [PW-1:0]   result_q;

    assign bExt = {b, 1'b0};
    assign aExt = {{WIDTH{a[WIDTH-1]}}, a};

    // Multiples are formed on the full product width, so 2*(-2^(WIDTH-1)) cannot wrap.
    // Negative rows are inverted here; their +1 is gathered into one extra row.
    always_comb begin
        booth_digit_t digit;
        logic [PW-1:0] mag;
        logic [PW-1:0] negInject;
        digit     = '0;
        mag       = '0;
        negInject = '0;
        for (int i = 0; i < NPP; i++) begin
            digit    = boothEncode(bExt[2*i +: 3]);
            mag      = digit.two ? (aExt << 1) : (digit.one ? aExt : '0);
            ppRow[i] = (digit.neg ? ~mag : mag) << (2 * i);
            negInject[2*i] = digit.neg;
        end
        ppRow[NPP] = negInject;
    end

    // Each stage folds the running sum/carry pair together with the next row.
    for (genvar k = 0; k < NCSA; k++) begin : gCsa
        if (k == 0) begin : gFirst
            csa_3to2 #(.N(PW)) uCsa (
                .x     (ppRow[0]),
                .y     (ppRow[1]),
                .z     (ppRow[2]),
                .sum   (csaSum[0]),
                .carry (csaCarry[0])
            );
        end else begin : gChain
            csa_3to2 #(.N(PW)) uCsa (
                .x     (csaSum[k-1]),
                .y     (csaCarry[k-1]),
                .z     (ppRow[k+2]),
                .sum   (csaSum[k]),
                .carry (csaCarry[k])
            );
        end
    end

    assign result_d = csaSum[NCSA-1] + csaCarry[NCSA-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the multiplier: a product model compared every cycle,
// directed vectors with literal expectations, then back-to-back random traffic.
module tb_multiplier;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] result;

    int checkCount = 0;
    int failCount  = 0;

    logic [63:0] expResult  = '0;
    logic        modelValid = 1'b0;

    multiplier dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: whatever was sampled at an edge becomes the exact signed product (or 0 in reset).
    always @(posedge clk) begin
        if (rst) begin
            expResult  <= '0;
            modelValid <= 1'b1;
        end else begin
            expResult <= 64'(longint'(int'(a)) * longint'(int'(b)));
        end
    end

    // Compare DUT against the model in the middle of every cycle once reset has been seen.
    always @(negedge clk) begin
        if (modelValid) begin
            checkCount++;
            if (result !== expResult) begin
                failCount++;
                $display("[TB] FAIL model_cmp t=%0t result=%h expected=%h", $time, result, expResult);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic irst);
        @(posedge clk);
        #2;
        a   = ia;
        b   = ib;
        rst = irst;
    endtask

    // Literal check of the product captured at the most recent edge; also pins the model.
    task automatic checkOutput(input string name, input logic [63:0] expected);
        checkCount++;
        if (result !== expected) begin
            failCount++;
            $display("[TB] FAIL %s result=%h expected=%h", name, result, expected);
        end
        checkCount++;
        if (expResult !== expected) begin
            failCount++;
            $display("[TB] FAIL %s_model model=%h expected=%h", name, expResult, expected);
        end
    endtask

    initial begin
        a   = 32'd5;
        b   = 32'd7;
        rst = 1'b1;

        applyStimulus(32'd5, 32'd7, 1'b1);
        applyStimulus(32'd5, 32'd7, 1'b1);
        checkOutput("reset_hold0", 64'h0);
        applyStimulus(32'd5, 32'd7, 1'b0);
        checkOutput("reset_hold1", 64'h0);

        applyStimulus(32'd50, -32'sd40, 1'b0);
        checkOutput("first_after_reset", 64'h23);
        applyStimulus(-32'sd10, 32'd325, 1'b0);
        checkOutput("mixed_50x-40", 64'hFFFF_FFFF_FFFF_F830);
        applyStimulus(-32'sd500, 32'd2000, 1'b0);
        checkOutput("mixed_-10x325", 64'hFFFF_FFFF_FFFF_F34E);
        applyStimulus(-32'sd999, 32'd999, 1'b0);
        checkOutput("mixed_-500x2000", 64'hFFFF_FFFF_FFF0_BDC0);
        applyStimulus(32'd90, 32'd70, 1'b0);
        checkOutput("mixed_-999x999", 64'hFFFF_FFFF_FFF0_C58F);
        applyStimulus(-32'sd80, -32'sd65, 1'b0);
        checkOutput("same_90x70", 64'h189C);
        applyStimulus(32'd98765, 32'd1, 1'b0);
        checkOutput("same_-80x-65", 64'h1450);
        applyStimulus(32'd98756, 32'd0, 1'b0);
        checkOutput("identity", 64'h181CD);
        applyStimulus(32'd0, 32'hFFFF_FFFF, 1'b0);
        checkOutput("zero_b", 64'h0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
        checkOutput("zero_a", 64'h0);
        applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        checkOutput("min_x_min", 64'h4000_0000_0000_0000);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkOutput("min_x_max", 64'hC000_0000_8000_0000);
        applyStimulus(32'd123, 32'd456, 1'b1);
        checkOutput("neg1_x_neg1", 64'h1);
        applyStimulus(32'd3, 32'd4, 1'b0);
        checkOutput("midstream_reset", 64'h0);
        applyStimulus(32'd0, 32'd0, 1'b0);
        checkOutput("after_midstream", 64'hC);

        for (int i = 0; i < 10000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 15))
                0: ra = 32'h8000_0000;
                1: rb = 32'h8000_0000;
                2: ra = 32'h7FFF_FFFF;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            applyStimulus(ra, rb, ($urandom_range(0, 31) == 0));
        end
        applyStimulus(32'd0, 32'd0, 1'b0);
        applyStimulus(32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
